// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq
// Micro-sequencer that runs one 8-bit operation per request on the 4-bit sm83
// ALU datapath. It loads the operands, runs the low-nibble and high-nibble
// passes (or a single shifter pass), computes Z/N/H/C, and returns the result
// with a one-cycle res_valid pulse. It owns every ALU control strobe. The
// unused ALU strobes (load_a_low, load_a_zero, load_b_lq, load_b_zero,
// op_a_oe, op_b_oe, bs_oe) are tied low by the parent.
//
// Ports
//   clk, nreset            clock (posedge), asynchronous active-low reset
//   req_valid/req_ready    request handshake; ready is high only in IDLE
//   req_op/a/b/cf/nf/hf    operation, operands and incoming flags (latched on accept)
//   res_valid              one-cycle result pulse
//   res_data, res_z/n/h/c  result and flags, held until the next res_valid
//   alu_din                value driven into the ALU shifter/bus
//   alu_dout, alu_carry, alu_zero, alu_dbh, alu_dbl   ALU status inputs
//   alu_load_a ... alu_op_b_mux                       registered ALU strobes
//
// Build option: define SM83_ALU_SEQ_DAA_EN to make op 15 execute DAA. This
// also adds the alu_daa_l_gt_9 / alu_daa_h_gt_9 / alu_daa_h_eq_9 inputs.
// Without it, op 15 returns A unchanged (OR with B forced to 0).
//
// Only ALU_WIDTH = 4 (8-bit word) is supported.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// LDA   | A driven through the shifter into ALU operand A
// LDB   | B (or the DAA correction) driven into ALU operand B
// LO    | low-nibble pass, half carry captured at the closing edge
// HI    | high-nibble pass, result and flags captured at the closing edge
// SHF   | single shifter pass for rotates/shifts, result captured at the closing edge
// DONE  | res_valid pulse

module sm83_alu_seq #(
   parameter int ALU_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [3:0]             req_op,
   input  logic [2*ALU_WIDTH-1:0] req_a,
   input  logic [2*ALU_WIDTH-1:0] req_b,
   input  logic                   req_cf,
   input  logic                   req_nf,
   input  logic                   req_hf,
   output logic                   res_valid,
   output logic [2*ALU_WIDTH-1:0] res_data,
   output logic                   res_z,
   output logic                   res_n,
   output logic                   res_h,
   output logic                   res_c,
   output logic [2*ALU_WIDTH-1:0] alu_din,
   input  logic [2*ALU_WIDTH-1:0] alu_dout,
   input  logic                   alu_carry,
   input  logic                   alu_zero,
   input  logic                   alu_dbh,
   input  logic                   alu_dbl,
`ifdef SM83_ALU_SEQ_DAA_EN
   input  logic                   alu_daa_l_gt_9,
   input  logic                   alu_daa_h_gt_9,
   input  logic                   alu_daa_h_eq_9,
`endif
   output logic                   alu_load_a,
   output logic                   alu_load_b,
   output logic                   alu_shift_l,
   output logic                   alu_shift_r,
   output logic                   alu_shift_in,
   output logic                   alu_carry_in,
   output logic                   alu_result_oe,
   output logic                   alu_shift_oe,
   output logic                   alu_r,
   output logic                   alu_s,
   output logic                   alu_v,
   output logic                   alu_negate,
   output logic                   alu_mux,
   output logic                   alu_op_b_mux
);

   localparam int WORD = 2*ALU_WIDTH;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_CP  = 4'd7;
   localparam logic [3:0] OP_RLC = 4'd8;
   localparam logic [3:0] OP_RRC = 4'd9;
   localparam logic [3:0] OP_RL  = 4'd10;
   localparam logic [3:0] OP_RR  = 4'd11;
   localparam logic [3:0] OP_SLA = 4'd12;
   localparam logic [3:0] OP_SRA = 4'd13;
   localparam logic [3:0] OP_DAA = 4'd15;

   typedef enum logic [2:0] {
      S_IDLE, S_LDA, S_LDB, S_LO, S_HI, S_SHF, S_DONE
   } state_t;

   state_t state, state_nx;

   logic [3:0]      op_q, op_e;
   logic [WORD-1:0] a_q, b_q, a_e, b_load;
   logic            cf_q, cf_e, hc_q;
   logic            accept;

   logic ctl_r, ctl_s, ctl_v, ctl_neg, cin_lo, is_add, is_sub;
   logic sh_left, sh_in;

   logic [WORD-1:0] din_nx;
   logic load_a_nx, load_b_nx, shift_l_nx, shift_r_nx, shift_in_nx, carry_in_nx;
   logic result_oe_nx, shift_oe_nx, r_nx, s_nx, v_nx, negate_nx, mux_nx, op_b_mux_nx;
   logic ready_nx, valid_nx;

`ifdef SM83_ALU_SEQ_DAA_EN
   logic nf_q, hf_q, daa_lo, daa_hi, daa_hi_q;

   // A > 0x99 is decided from the nibble compares of the loaded ALU operand A;
   // they are valid once A loads on the negedge inside LDA.
   assign daa_lo = hf_q || (!nf_q && alu_daa_l_gt_9);
   assign daa_hi = cf_q || (!nf_q && (alu_daa_h_gt_9 || (alu_daa_h_eq_9 && alu_daa_l_gt_9)));
`else
   logic unused_req_flags;
   assign unused_req_flags = req_nf ^ req_hf;
`endif

   function automatic logic is_shift(input logic [3:0] op);
      return op[3] && (op != OP_DAA);
   endfunction

   // Next state; op/A/cf are taken straight from the request in the accept
   // cycle so the first state's registered strobes are correct on entry.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      op_e     = op_q;
      a_e      = a_q;
      cf_e     = cf_q;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               accept   = 1'b1;
               op_e     = req_op;
               a_e      = req_a;
               cf_e     = req_cf;
               state_nx = is_shift(req_op) ? S_SHF : S_LDA;
            end
         end
         S_LDA:   state_nx = S_LDB;
         S_LDB:   state_nx = S_LO;
         S_LO:    state_nx = S_HI;
         S_HI:    state_nx = S_DONE;
         S_SHF:   state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Nibble-pass controls; only used in LO/HI where op_q is already latched.
   always_comb begin
      ctl_r   = 1'b0;
      ctl_s   = 1'b0;
      ctl_v   = 1'b0;
      ctl_neg = 1'b0;
      cin_lo  = 1'b0;
      is_add  = 1'b0;
      is_sub  = 1'b0;
      case (op_q)
         OP_ADD: is_add = 1'b1;
         OP_ADC: begin is_add = 1'b1; cin_lo = cf_q; end
         OP_SUB, OP_CP: begin is_sub = 1'b1; ctl_neg = 1'b1; cin_lo = 1'b1; end
         OP_SBC: begin is_sub = 1'b1; ctl_neg = 1'b1; cin_lo = !cf_q; end
         OP_AND: begin ctl_s = 1'b1; cin_lo = 1'b1; end
         OP_XOR: ctl_r = 1'b1;
         OP_OR:  begin ctl_r = 1'b1; ctl_v = 1'b1; end
`ifdef SM83_ALU_SEQ_DAA_EN
         OP_DAA: begin
            if (nf_q) begin is_sub = 1'b1; ctl_neg = 1'b1; cin_lo = 1'b1; end
            else      is_add = 1'b1;
         end
`else
         OP_DAA: begin ctl_r = 1'b1; ctl_v = 1'b1; end
`endif
         default: ;
      endcase
   end

   always_comb begin
      sh_left = (op_e == OP_RLC) || (op_e == OP_RL) || (op_e == OP_SLA);
      case (op_e)
         OP_RLC, OP_SRA: sh_in = a_e[WORD-1];
         OP_RRC:         sh_in = a_e[0];
         OP_RL, OP_RR:   sh_in = cf_e;
         default:        sh_in = 1'b0;
      endcase
   end

`ifdef SM83_ALU_SEQ_DAA_EN
   assign b_load = (op_q == OP_DAA) ? {1'b0, daa_hi, daa_hi, 2'b00, daa_lo, daa_lo, 1'b0} : b_q;
`else
   assign b_load = (op_q == OP_DAA) ? '0 : b_q;
`endif

   // Strobe values for the state being entered; registered below so every
   // alu_* output is a clean Moore output of the state.
   always_comb begin
      din_nx       = '0;
      load_a_nx    = 1'b0;
      load_b_nx    = 1'b0;
      shift_l_nx   = 1'b0;
      shift_r_nx   = 1'b0;
      shift_in_nx  = 1'b0;
      carry_in_nx  = 1'b0;
      result_oe_nx = 1'b0;
      shift_oe_nx  = 1'b0;
      r_nx         = 1'b0;
      s_nx         = 1'b0;
      v_nx         = 1'b0;
      negate_nx    = 1'b0;
      mux_nx       = 1'b0;
      op_b_mux_nx  = 1'b0;
      ready_nx     = 1'b0;
      valid_nx     = 1'b0;
      case (state_nx)
         S_IDLE: ready_nx = 1'b1;
         S_LDA: begin
            din_nx      = a_e;
            shift_oe_nx = 1'b1;
            load_a_nx   = 1'b1;
         end
         S_LDB: begin
            din_nx      = b_load;
            shift_oe_nx = 1'b1;
            load_b_nx   = 1'b1;
         end
         S_LO: begin
            r_nx        = ctl_r;
            s_nx        = ctl_s;
            v_nx        = ctl_v;
            negate_nx   = ctl_neg;
            carry_in_nx = cin_lo;
         end
         S_HI: begin
            r_nx         = ctl_r;
            s_nx         = ctl_s;
            v_nx         = ctl_v;
            negate_nx    = ctl_neg;
            // HI is only entered from LO, so the live carry is the half carry.
            carry_in_nx  = alu_carry;
            mux_nx       = 1'b1;
            op_b_mux_nx  = 1'b1;
            result_oe_nx = 1'b1;
         end
         S_SHF: begin
            din_nx      = a_e;
            shift_oe_nx = 1'b1;
            shift_l_nx  = sh_left;
            shift_r_nx  = !sh_left;
            shift_in_nx = sh_in;
         end
         S_DONE: valid_nx = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state         <= S_IDLE;
         req_ready     <= 1'b1;
         res_valid     <= 1'b0;
         alu_din       <= '0;
         alu_load_a    <= 1'b0;
         alu_load_b    <= 1'b0;
         alu_shift_l   <= 1'b0;
         alu_shift_r   <= 1'b0;
         alu_shift_in  <= 1'b0;
         alu_carry_in  <= 1'b0;
         alu_result_oe <= 1'b0;
         alu_shift_oe  <= 1'b0;
         alu_r         <= 1'b0;
         alu_s         <= 1'b0;
         alu_v         <= 1'b0;
         alu_negate    <= 1'b0;
         alu_mux       <= 1'b0;
         alu_op_b_mux  <= 1'b0;
      end else begin
         state         <= state_nx;
         req_ready     <= ready_nx;
         res_valid     <= valid_nx;
         alu_din       <= din_nx;
         alu_load_a    <= load_a_nx;
         alu_load_b    <= load_b_nx;
         alu_shift_l   <= shift_l_nx;
         alu_shift_r   <= shift_r_nx;
         alu_shift_in  <= shift_in_nx;
         alu_carry_in  <= carry_in_nx;
         alu_result_oe <= result_oe_nx;
         alu_shift_oe  <= shift_oe_nx;
         alu_r         <= r_nx;
         alu_s         <= s_nx;
         alu_v         <= v_nx;
         alu_negate    <= negate_nx;
         alu_mux       <= mux_nx;
         alu_op_b_mux  <= op_b_mux_nx;
      end
   end

   // Result registers change on the edge into DONE, i.e. together with res_valid.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cf_q     <= 1'b0;
         hc_q     <= 1'b0;
         res_data <= '0;
         res_z    <= 1'b0;
         res_n    <= 1'b0;
         res_h    <= 1'b0;
         res_c    <= 1'b0;
`ifdef SM83_ALU_SEQ_DAA_EN
         nf_q     <= 1'b0;
         hf_q     <= 1'b0;
         daa_hi_q <= 1'b0;
`endif
      end else begin
         if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            cf_q <= req_cf;
`ifdef SM83_ALU_SEQ_DAA_EN
            nf_q <= req_nf;
            hf_q <= req_hf;
`endif
         end
         if (state == S_LO) hc_q <= alu_carry;
`ifdef SM83_ALU_SEQ_DAA_EN
         if (state == S_LDA) daa_hi_q <= daa_hi;
`endif
         if (state == S_HI) begin
            res_data <= (op_q == OP_CP) ? a_q : alu_dout;
            res_z    <= alu_zero;
            res_n    <= is_sub;
            res_h    <= is_add ? hc_q : (is_sub ? !hc_q : (op_q == OP_AND));
            res_c    <= is_add ? alu_carry : (is_sub ? !alu_carry : 1'b0);
`ifdef SM83_ALU_SEQ_DAA_EN
            if (op_q == OP_DAA) begin
               res_h <= 1'b0;
               res_c <= cf_q | daa_hi_q;
            end
`endif
         end
         if (state == S_SHF) begin
            res_data <= alu_dout;
            res_z    <= alu_zero;
            res_n    <= 1'b0;
            res_h    <= 1'b0;
            res_c    <= alu_shift_l ? alu_dbh : alu_dbl;
         end
      end
   end

endmodule

// File: tb/tb_sm83_alu_seq.sv
// Bench for sm83_alu_seq: a behavioural 4-bit ALU answers the sequencer's
// strobes, and every result is compared with an 8-bit arithmetic reference.
module tb_sm83_alu_seq;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_CP  = 4'd7;
   localparam logic [3:0] OP_RLC = 4'd8;
   localparam logic [3:0] OP_RRC = 4'd9;
   localparam logic [3:0] OP_RL  = 4'd10;
   localparam logic [3:0] OP_RR  = 4'd11;
   localparam logic [3:0] OP_SLA = 4'd12;
   localparam logic [3:0] OP_SRA = 4'd13;
   localparam logic [3:0] OP_SRL = 4'd14;
   localparam logic [3:0] OP_DAA = 4'd15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       nreset, req_valid, req_ready, req_cf, req_nf, req_hf;
   logic [3:0] req_op;
   logic [7:0] req_a, req_b;
   logic       res_valid, res_z, res_n, res_h, res_c;
   logic [7:0] res_data, alu_din, alu_dout;
   logic       alu_carry, alu_zero, alu_dbh, alu_dbl;
   logic       alu_load_a, alu_load_b, alu_shift_l, alu_shift_r, alu_shift_in, alu_carry_in;
   logic       alu_result_oe, alu_shift_oe, alu_r, alu_s, alu_v, alu_negate, alu_mux, alu_op_b_mux;
`ifdef SM83_ALU_SEQ_DAA_EN
   logic       alu_daa_l_gt_9, alu_daa_h_gt_9, alu_daa_h_eq_9;
`endif

   sm83_alu_seq #(.ALU_WIDTH(4)) dut (
      .clk(clk), .nreset(nreset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_cf(req_cf), .req_nf(req_nf), .req_hf(req_hf),
      .res_valid(res_valid), .res_data(res_data),
      .res_z(res_z), .res_n(res_n), .res_h(res_h), .res_c(res_c),
      .alu_din(alu_din), .alu_dout(alu_dout),
      .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_dbh(alu_dbh), .alu_dbl(alu_dbl),
`ifdef SM83_ALU_SEQ_DAA_EN
      .alu_daa_l_gt_9(alu_daa_l_gt_9), .alu_daa_h_gt_9(alu_daa_h_gt_9),
      .alu_daa_h_eq_9(alu_daa_h_eq_9),
`endif
      .alu_load_a(alu_load_a), .alu_load_b(alu_load_b),
      .alu_shift_l(alu_shift_l), .alu_shift_r(alu_shift_r), .alu_shift_in(alu_shift_in),
      .alu_carry_in(alu_carry_in), .alu_result_oe(alu_result_oe), .alu_shift_oe(alu_shift_oe),
      .alu_r(alu_r), .alu_s(alu_s), .alu_v(alu_v), .alu_negate(alu_negate),
      .alu_mux(alu_mux), .alu_op_b_mux(alu_op_b_mux)
   );

   // ---------------- behavioural 4-bit ALU ----------------
   logic [7:0] ra = 8'h00, rb = 8'h00, sh_out;
   logic [3:0] rlo = 4'h0, na, nb, nr;
   logic [4:0] sum5;
   logic       ncy;

   always_comb begin
      sh_out = alu_din;
      if (alu_shift_l)      sh_out = {alu_din[6:0], alu_shift_in};
      else if (alu_shift_r) sh_out = {alu_shift_in, alu_din[7:1]};
      na = alu_mux ? ra[7:4] : ra[3:0];
      nb = alu_op_b_mux ? rb[7:4] : rb[3:0];
      if (alu_negate) nb = ~nb;
      sum5 = {1'b0, na} + {1'b0, nb} + {4'b0000, alu_carry_in};
      nr   = sum5[3:0];
      ncy  = sum5[4];
      if (alu_r) begin
         nr  = alu_v ? (na | nb) : (na ^ nb);
         ncy = 1'b0;
      end else if (alu_s) begin
         nr  = na & nb;
         ncy = 1'b0;
      end
   end

   assign alu_dout  = alu_result_oe ? {nr, rlo} : (alu_shift_oe ? sh_out : 8'h00);
   assign alu_zero  = (alu_dout == 8'h00);
   assign alu_carry = ncy;
   assign alu_dbh   = alu_din[7];
   assign alu_dbl   = alu_din[0];
`ifdef SM83_ALU_SEQ_DAA_EN
   assign alu_daa_l_gt_9 = (ra[3:0] > 4'd9);
   assign alu_daa_h_gt_9 = (ra[7:4] > 4'd9);
   assign alu_daa_h_eq_9 = (ra[7:4] == 4'd9);
`endif

   always @(negedge clk) begin
      if (alu_load_a) ra <= sh_out;
      if (alu_load_b) rb <= sh_out;
   end
   always @(posedge clk) if (!alu_mux) rlo <= nr;

   // ---------------- checking ----------------
   int n_chk = 0, n_pass = 0;
   logic [11:0] prev = 12'h000;
   wire  [11:0] res_pack = {res_data, res_z, res_n, res_h, res_c};
   wire  [21:0] alu_all  = {alu_din, alu_load_a, alu_load_b, alu_shift_l, alu_shift_r,
                            alu_shift_in, alu_carry_in, alu_result_oe, alu_shift_oe,
                            alu_r, alu_s, alu_v, alu_negate, alu_mux, alu_op_b_mux};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
   endtask

   task automatic ref_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cf, input logic nf, input logic hf,
                         output logic [7:0] r, output logic z, output logic n,
                         output logic h, output logic c);
      int ci, s;
      logic [7:0] corr;
      r = a; n = 1'b0; h = 1'b0; c = 1'b0;
      ci = (op == OP_ADC || op == OP_SBC) ? int'(cf) : 0;
      case (op)
         OP_ADD, OP_ADC: begin
            s = int'(a) + int'(b) + ci;
            r = 8'(s);
            h = (int'(a[3:0]) + int'(b[3:0]) + ci) > 15;
            c = s > 255;
         end
         OP_SUB, OP_SBC, OP_CP: begin
            r = 8'(int'(a) - int'(b) - ci);
            h = int'(a[3:0]) < int'(b[3:0]) + ci;
            c = int'(a) < int'(b) + ci;
            n = 1'b1;
         end
         OP_AND: begin r = a & b; h = 1'b1; end
         OP_XOR: r = a ^ b;
         OP_OR:  r = a | b;
         OP_RLC: begin r = {a[6:0], a[7]}; c = a[7]; end
         OP_RRC: begin r = {a[0], a[7:1]}; c = a[0]; end
         OP_RL:  begin r = {a[6:0], cf};   c = a[7]; end
         OP_RR:  begin r = {cf, a[7:1]};   c = a[0]; end
         OP_SLA: begin r = {a[6:0], 1'b0}; c = a[7]; end
         OP_SRA: begin r = {a[7], a[7:1]}; c = a[0]; end
         OP_SRL: begin r = {1'b0, a[7:1]}; c = a[0]; end
         default: begin
`ifdef SM83_ALU_SEQ_DAA_EN
            corr = 8'h00;
            if (hf || (!nf && a[3:0] > 4'd9)) corr = corr + 8'h06;
            if (cf || (!nf && a > 8'h99))     corr = corr + 8'h60;
            r = nf ? a - corr : a + corr;
            c = cf || (corr >= 8'h60);
            n = nf;
`else
            corr = 8'h00;
            r = a | corr;
`endif
         end
      endcase
      z = (r == 8'h00);
      if (op == OP_CP) r = a;
   endtask

   task automatic scramble_req();
      req_valid = 1'b1;
      req_op = 4'($urandom_range(0, 15));
      req_a  = 8'($urandom);
      req_b  = 8'($urandom);
      req_cf = 1'($urandom_range(0, 1));
      req_nf = 1'($urandom_range(0, 1));
      req_hf = 1'($urandom_range(0, 1));
   endtask

   task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cf, input logic nf, input logic hf, input bit garbage);
      logic [7:0] er;
      logic ez, en, eh, ec;
      int lat, exp_lat;
      bit got;
      ref_op(op, a, b, cf, nf, hf, er, ez, en, eh, ec);
      exp_lat = (op >= OP_RLC && op <= OP_SRL) ? 2 : 5;
      @(negedge clk);
      chk("idle.ready", 32'(req_ready), 32'd1);
      chk("idle.valid", 32'(res_valid), 32'd0);
      chk("held", 32'(res_pack), 32'(prev));
      req_op = op; req_a = a; req_b = b; req_cf = cf; req_nf = nf; req_hf = hf;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      if (garbage) scramble_req();
      else req_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (res_valid) got = 1'b1;
         else begin
            chk("busy.ready", 32'(req_ready), 32'd0);
            if (garbage) scramble_req();
         end
      end
      req_valid = 1'b0;
      chk($sformatf("op%0d.latency", op), 32'(lat), 32'(exp_lat));
      chk($sformatf("op%0d a=%02h b=%02h cf=%0d data", op, a, b, cf), 32'(res_data), 32'(er));
      chk($sformatf("op%0d a=%02h b=%02h flags", op, a, b), 32'({res_z, res_n, res_h, res_c}),
          32'({ez, en, eh, ec}));
      prev = {er, ez, en, eh, ec};
   endtask

   task automatic reset_mid_op();
      int seen;
      @(negedge clk);
      req_op = OP_SUB; req_a = 8'h55; req_b = 8'h22; req_cf = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.in_lo", 32'({alu_negate, alu_carry_in, alu_mux}), 32'b110);
      nreset = 1'b0;
      #1;
      chk("rst.alu", 32'(alu_all), 32'd0);
      chk("rst.valid", 32'(res_valid), 32'd0);
      chk("rst.ready", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      chk("rst.no_valid", 32'(seen), 32'd0);
      chk("rst.ready_after", 32'(req_ready), 32'd1);
      prev = 12'h000;
   endtask

   initial begin
      nreset = 1'b0;
      req_valid = 1'b0; req_op = 4'd0; req_a = 8'h00; req_b = 8'h00;
      req_cf = 1'b0; req_nf = 1'b0; req_hf = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.ready", 32'(req_ready), 32'd1);
      chk("reset.valid", 32'(res_valid), 32'd0);
      chk("reset.alu", 32'(alu_all), 32'd0);
      chk("reset.res", 32'(res_pack), 32'd0);
      nreset = 1'b1;

      do_op(OP_ADD, 8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("plan.add", 32'(res_pack), 32'({8'h00, 4'b1011}));
      do_op(OP_SBC, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("plan.sbc", 32'(res_pack), 32'({8'h0E, 4'b0110}));
      do_op(OP_CP, 8'h42, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("plan.cp", 32'(res_pack), 32'({8'h42, 4'b1100}));
      do_op(OP_AND, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("plan.and", 32'(res_pack), 32'({8'h30, 4'b0010}));
      do_op(OP_RLC, 8'h85, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("plan.rlc", 32'(res_pack), 32'({8'h0B, 4'b0001}));
      do_op(OP_SRA, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("plan.sra", 32'(res_pack), 32'({8'hC0, 4'b0001}));
      do_op(OP_RR, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("plan.rr", 32'(res_pack), 32'({8'h00, 4'b1001}));

      reset_mid_op();
      do_op(OP_ADD, 8'h15, 8'h27, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("plan.after_rst", 32'(res_pack), 32'({8'h3C, 4'b0000}));

`ifdef SM83_ALU_SEQ_DAA_EN
      do_op(OP_DAA, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("plan.daa42", 32'(res_pack), 32'({8'h42, 4'b0000}));
      do_op(OP_DAA, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("plan.daa9a", 32'(res_pack), 32'({8'h00, 4'b1001}));
`else
      do_op(OP_DAA, 8'h5A, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("plan.undef", 32'(res_pack), 32'({8'h5A, 4'b0000}));
`endif

      for (int i = 0; i < 300; i++) begin
         do_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
